// File: rtl/cpu_reg_wb_scheduler.sv
// cpu_reg_wb_scheduler: register-bank access sequencer.
// Scoreboard with one busy bit per architectural register that stalls issue
// on RAW/WAW hazards, plus a round-robin arbiter that moves two writeback
// requesters (req0 = ALU, req1 = MEM) onto the bank's single write port
// through a registered write stage.
//
// Handshake: a requester raises reqN_valid with reqN_reg/reqN_data and holds
// all three stable until it sees reqN_ready high in the same cycle; that
// cycle is the transfer. issue_ready is the issue-side equivalent: the
// instruction presented with issue_valid is accepted in any cycle where
// issue_ready is high, and is not accepted otherwise.
module cpu_reg_wb_scheduler #(
  parameter int NUM_REGS  = 16,
  parameter int REG_WIDTH = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  // Issue stage
  input  logic                 issue_valid,
  input  logic                 issue_dst_valid,
  input  logic [ADDR_W-1:0]    issue_dst,
  input  logic [ADDR_W-1:0]    issue_rs_a,
  input  logic [ADDR_W-1:0]    issue_rs_b,
  output logic                 issue_ready,
  // Writeback requester 0 (ALU)
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_reg,
  input  logic [REG_WIDTH-1:0] req0_data,
  output logic                 req0_ready,
  // Writeback requester 1 (MEM)
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_reg,
  input  logic [REG_WIDTH-1:0] req1_data,
  output logic                 req1_ready,
  // Register bank write port
  output logic                 write_enable,
  output logic [ADDR_W-1:0]    write_reg,
  output logic [REG_WIDTH-1:0] write_data,
  // Scoreboard status
  output logic [NUM_REGS-1:0]  busy,
  output logic [ADDR_W:0]      pending_count,
  output logic                 err_wb_not_busy
);

  // Scoreboard state
  logic [NUM_REGS-1:0]  busy_q,  busy_d;
  logic [ADDR_W:0]      pend_q,  pend_d;
  logic                 err_q,   err_d;

  // Arbiter pointer: 1 means req1 wins the next contended cycle.
  logic                 rr_q,    rr_d;

  // Registered write stage
  logic                 we_q,    we_d;
  logic [ADDR_W-1:0]    wreg_q,  wreg_d;
  logic [REG_WIDTH-1:0] wdata_q, wdata_d;

  // Combinational grant signals
  logic                 gnt0, gnt1, gnt_any, contended;
  logic [ADDR_W-1:0]    win_reg;
  logic [REG_WIDTH-1:0] win_data;
  logic                 issue_set;

  // Hazard check against registered busy bits only; no bypass from the write stage.
  always_comb begin
    issue_ready = issue_valid
                & ~busy_q[issue_rs_a]
                & ~busy_q[issue_rs_b]
                & ~(issue_dst_valid & busy_q[issue_dst]);
    issue_set   = issue_ready & issue_dst_valid;
  end

  // Round-robin grant: a lone requester always wins, contention follows rr_q.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    contended = req0_valid & req1_valid;
    if (contended) begin
      if (rr_q) gnt1 = 1'b1;
      else      gnt0 = 1'b1;
    end else if (req0_valid) begin
      gnt0 = 1'b1;
    end else if (req1_valid) begin
      gnt1 = 1'b1;
    end
    gnt_any    = gnt0 | gnt1;
    win_reg    = gnt1 ? req1_reg  : req0_reg;
    win_data   = gnt1 ? req1_data : req0_data;
    req0_ready = gnt0;
    req1_ready = gnt1;
  end

  // Pointer moves only when both requesters competed; it then favours the loser.
  always_comb begin
    rr_d = rr_q;
    if (contended) rr_d = gnt0;
  end

  // Write stage capture: strobe follows the grant; index/data hold when idle.
  always_comb begin
    we_d    = gnt_any;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (gnt_any) begin
      wreg_d  = win_reg;
      wdata_d = win_data;
    end
  end

  // Busy update: clear on the bank-write edge, set on issue accept.
  // The two never hit the same index because issue stalls on a busy dst.
  always_comb begin
    busy_d = busy_q;
    if (we_q)      busy_d[wreg_q]    = 1'b0;
    if (issue_set) busy_d[issue_dst] = 1'b1;
  end

  // Population count of next busy vector, registered alongside it.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_d = pend_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // Sticky error: a granted writeback targeted a register that was not busy.
  always_comb begin
    err_d = err_q | (gnt_any & ~busy_q[win_reg]);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  // Output mapping
  always_comb begin
    write_enable    = we_q;
    write_reg       = wreg_q;
    write_data      = wdata_q;
    busy            = busy_q;
    pending_count   = pend_q;
    err_wb_not_busy = err_q;
  end

endmodule

// File: tb/tb_cpu_reg_wb_scheduler.sv
// Testbench for cpu_reg_wb_scheduler: directed scenarios followed by random
// issue/writeback traffic, checked against a register-level reference model
// and a write-port scoreboard.
module tb_cpu_reg_wb_scheduler;

  localparam int NUM_REGS  = 16;
  localparam int REG_WIDTH = 32;
  localparam int ADDR_W    = $clog2(NUM_REGS);
  localparam int WB_W      = ADDR_W + REG_WIDTH;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT ports ----------------
  logic                 issue_valid, issue_dst_valid, issue_ready;
  logic [ADDR_W-1:0]    issue_dst, issue_rs_a, issue_rs_b;
  logic                 req0_valid, req0_ready, req1_valid, req1_ready;
  logic [ADDR_W-1:0]    req0_reg, req1_reg;
  logic [REG_WIDTH-1:0] req0_data, req1_data;
  logic                 write_enable;
  logic [ADDR_W-1:0]    write_reg;
  logic [REG_WIDTH-1:0] write_data;
  logic [NUM_REGS-1:0]  busy;
  logic [ADDR_W:0]      pending_count;
  logic                 err_wb_not_busy;

  cpu_reg_wb_scheduler #(.NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_dst_valid(issue_dst_valid),
    .issue_dst(issue_dst), .issue_rs_a(issue_rs_a), .issue_rs_b(issue_rs_b),
    .issue_ready(issue_ready),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .busy(busy), .pending_count(pending_count), .err_wb_not_busy(err_wb_not_busy)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [WB_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Set of registers awaiting writeback, the sticky error, which requester
  // wins the next tie, and the write currently sitting at the bank port.
  bit m_busy[NUM_REGS];
  bit m_err;
  bit m_pref1;
  bit m_wv;
  int m_wreg;
  int g_win;   // requester granted in the last stepped cycle, -1 for none
  bit g_acc;   // issue accepted in the last stepped cycle

  function automatic logic [NUM_REGS-1:0] model_busy_vec();
    logic [NUM_REGS-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int model_pending();
    int s = 0;
    for (int i = 0; i < NUM_REGS; i++) s += m_busy[i] ? 1 : 0;
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
    m_err = 1'b0; m_pref1 = 1'b0; m_wv = 1'b0; m_wreg = 0;
  endtask

  // One clock cycle: compare outputs mid-cycle, push the expected write,
  // then advance the model across the rising edge.
  task automatic step();
    bit exp_ready;
    int wr;
    @(negedge clock);
    exp_ready = issue_valid && !m_busy[issue_rs_a] && !m_busy[issue_rs_b]
                && !(issue_dst_valid && m_busy[issue_dst]);
    if (req0_valid && req1_valid) g_win = m_pref1 ? 1 : 0;
    else if (req0_valid)          g_win = 0;
    else if (req1_valid)          g_win = 1;
    else                          g_win = -1;
    g_acc = exp_ready;
    check("issue_ready",   issue_ready,     exp_ready);
    check("req0_ready",    req0_ready,      g_win == 0);
    check("req1_ready",    req1_ready,      g_win == 1);
    check("busy",          busy,            model_busy_vec());
    check("pending_count", pending_count,   model_pending());
    check("err_wb",        err_wb_not_busy, m_err);
    check("write_enable",  write_enable,    m_wv);
    if (!reset && g_win >= 0)
      exp_q.push_back(g_win == 0 ? {req0_reg, req0_data} : {req1_reg, req1_data});
    @(posedge clock);
    if (reset) begin
      model_clear();
    end else begin
      wr = (g_win == 1) ? int'(req1_reg) : int'(req0_reg);
      if (g_win >= 0 && !m_busy[wr]) m_err = 1'b1;
      if (m_wv) m_busy[m_wreg] = 1'b0;
      if (exp_ready && issue_dst_valid) m_busy[issue_dst] = 1'b1;
      if (req0_valid && req1_valid) m_pref1 = (g_win == 0);
      m_wv = (g_win >= 0);
      if (g_win >= 0) m_wreg = wr;
    end
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [WB_W-1:0] e;
    forever begin
      @(negedge clock);
      if (write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL wb_unexpected: got r%0d=0x%0h expected no write", write_reg, write_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_write", {write_reg, write_data}, e);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic idle_all();
    issue_valid = 0; issue_dst_valid = 0; issue_dst = 0; issue_rs_a = 0; issue_rs_b = 0;
    req0_valid = 0; req0_reg = 0; req0_data = 0;
    req1_valid = 0; req1_reg = 0; req1_data = 0;
  endtask

  task automatic drive_issue(input bit dv, input int dst, input int ra, input int rb);
    issue_valid = 1; issue_dst_valid = dv;
    issue_dst = ADDR_W'(dst); issue_rs_a = ADDR_W'(ra); issue_rs_b = ADDR_W'(rb);
  endtask

  task automatic issue_dst_only(input int dst);
    drive_issue(1, dst, 0, 0);
    step();
    issue_valid = 0; issue_dst_valid = 0;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main stimulus ----------------
  int  alu_jobs[$];
  int  mem_jobs[$];
  bit  r0_act, r1_act;
  int  budget;

  initial begin
    idle_all();
    model_clear();
    g_win = -1;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Reset state
    check("rst_busy",  busy, 16'h0000);
    check("rst_pend",  pending_count, 0);
    check("rst_we",    write_enable, 0);
    check("rst_wreg",  write_reg, 0);
    check("rst_wdata", write_data, 0);
    check("rst_err",   err_wb_not_busy, 0);

    // RAW: dst=3 busy, consumer stalls until two cycles after grant
    issue_dst_only(3);
    check("t1_busy", busy, 16'h0008);
    check("t1_pend", pending_count, 1);
    drive_issue(0, 0, 3, 0);
    #1 check("t1_raw_stall", issue_ready, 0);
    step();
    req0_valid = 1; req0_reg = 3; req0_data = 32'hDEADBEEF;
    #1 check("t1_grant", req0_ready, 1);
    step();
    req0_valid = 0;
    check("t1_we",    write_enable, 1);
    check("t1_wreg",  write_reg, 3);
    check("t1_wdata", write_data, 32'hDEADBEEF);
    #1 check("t1_still_stalled", issue_ready, 0);
    step();
    #1 check("t1_released", issue_ready, 1);
    check("t1_busy_clear", busy, 16'h0000);
    step();
    idle_all();

    // Contended pair: req0 first, then req1
    issue_dst_only(1);
    issue_dst_only(2);
    req0_valid = 1; req0_reg = 1; req0_data = 32'h11;
    req1_valid = 1; req1_reg = 2; req1_data = 32'h22;
    #1 check("t2_g0", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 0;
    check("t2_w1_reg", write_reg, 1);
    check("t2_w1_dat", write_data, 32'h11);
    #1 check("t2_g1", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 0;
    check("t2_w2_reg", write_reg, 2);
    check("t2_w2_dat", write_data, 32'h22);
    idle_steps(2);

    // Four contended rounds alternate 0,1,0,1; lone grants leave the pointer alone
    do_reset();
    for (int r = 8; r <= 14; r++) issue_dst_only(r);
    req0_valid = 1; req0_reg = 8; req0_data = 32'h108;
    req1_valid = 1; req1_reg = 9; req1_data = 32'h109;
    #1 check("t3_round0", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_reg = 10; req0_data = 32'h10A;
    #1 check("t3_round1", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_reg = 11; req1_data = 32'h10B;
    #1 check("t3_round2", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_reg = 12; req0_data = 32'h10C;
    #1 check("t3_round3", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 0;
    #1 check("t3_lone0", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_reg = 14; req0_data = 32'h10E;
    req1_valid = 1; req1_reg = 13; req1_data = 32'h10D;
    #1 check("t3_after_lone", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 0;
    #1 check("t3_lone1", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 0;
    idle_steps(3);
    check("t3_busy_empty", busy, 16'h0000);

    // WAW on r5
    issue_dst_only(5);
    drive_issue(1, 5, 1, 2);
    #1 check("t4_waw_stall", issue_ready, 0);
    step(); step();
    req0_valid = 1; req0_reg = 5; req0_data = 32'h55;
    step();
    req0_valid = 0;
    step();
    #1 check("t4_waw_release", issue_ready, 1);
    check("t4_pend_cleared", pending_count, 0);
    step();
    idle_all();
    check("t4_busy_again", busy, 16'h0020);
    check("t4_pend_again", pending_count, 1);
    req0_valid = 1; req0_reg = 5; req0_data = 32'h56;
    step();
    req0_valid = 0;
    idle_steps(2);

    // Writeback to a non-busy register raises the sticky error
    check("t5_busy_zero", busy, 16'h0000);
    req1_valid = 1; req1_reg = 7; req1_data = 32'h77;
    step();
    req1_valid = 0;
    check("t5_we",   write_enable, 1);
    check("t5_wreg", write_reg, 7);
    check("t5_err",  err_wb_not_busy, 1);
    idle_steps(3);
    check("t5_err_sticky", err_wb_not_busy, 1);
    do_reset();
    check("t5_err_reset", err_wb_not_busy, 0);

    // Reset the cycle after a grant drops the pending state
    issue_dst_only(4);
    req0_valid = 1; req0_reg = 4; req0_data = 32'h44;
    step();
    req0_valid = 0;
    reset = 1;
    check("t6_inflight", write_enable, 1);
    step();
    reset = 0;
    check("t6_we",   write_enable, 0);
    check("t6_busy", busy, 16'h0000);
    check("t6_pend", pending_count, 0);
    idle_steps(1);

    // Random traffic: each accepted dst becomes one writeback job
    r0_act = 0; r1_act = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!r0_act && alu_jobs.size() > 0 && $urandom_range(0, 3) != 0) begin
        r0_act = 1; req0_reg = ADDR_W'(alu_jobs.pop_front()); req0_data = $urandom();
      end
      if (!r1_act && mem_jobs.size() > 0 && $urandom_range(0, 3) != 0) begin
        r1_act = 1; req1_reg = ADDR_W'(mem_jobs.pop_front()); req1_data = $urandom();
      end
      req0_valid = r0_act;
      req1_valid = r1_act;
      issue_valid     = ($urandom_range(0, 2) != 0);
      issue_dst_valid = ($urandom_range(0, 3) != 0);
      issue_dst       = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      issue_rs_a      = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      issue_rs_b      = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      step();
      if (g_win == 0) r0_act = 0;
      if (g_win == 1) r1_act = 0;
      if (g_acc && issue_dst_valid) begin
        if ($urandom_range(0, 1) == 0) alu_jobs.push_back(int'(issue_dst));
        else                           mem_jobs.push_back(int'(issue_dst));
      end
    end

    // Drain outstanding jobs
    issue_valid = 0; issue_dst_valid = 0;
    budget = 300;
    while ((alu_jobs.size() > 0 || mem_jobs.size() > 0 || r0_act || r1_act) && budget > 0) begin
      if (!r0_act && alu_jobs.size() > 0) begin
        r0_act = 1; req0_reg = ADDR_W'(alu_jobs.pop_front()); req0_data = $urandom();
      end
      if (!r1_act && mem_jobs.size() > 0) begin
        r1_act = 1; req1_reg = ADDR_W'(mem_jobs.pop_front()); req1_data = $urandom();
      end
      req0_valid = r0_act;
      req1_valid = r1_act;
      step();
      if (g_win == 0) r0_act = 0;
      if (g_win == 1) r1_act = 0;
      budget--;
    end
    if (budget == 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: jobs left alu=%0d mem=%0d expected 0", alu_jobs.size(), mem_jobs.size());
    end
    req0_valid = 0; req1_valid = 0;
    idle_steps(3);
    check("final_busy",  busy, 16'h0000);
    check("final_err",   err_wb_not_busy, 0);
    check("final_exp_q", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
